// File: rtl/sargantana_itag_ctrl.sv
// Instruction-cache tag/valid array controller.
// Owns the single read-or-write port of the tag array: it sweeps every set
// invalid after reset or on request, writes refill tags into a round-robin
// victim way, and issues fetch lookups whose 1-cycle-latency result is
// flagged one cycle later on rsp_valid_o / rsp_addr_o.
module sargantana_itag_ctrl #(
  parameter int ICACHE_N_WAY   = 4,
  parameter int TAG_DEPTH      = 64,
  parameter int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
  parameter int TAG_WIDHT      = 20
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      lookup_valid_i,
  input  logic [TAG_ADDR_WIDHT-1:0] lookup_addr_i,
  output logic                      lookup_ready_o,
  output logic                      rsp_valid_o,
  output logic [TAG_ADDR_WIDHT-1:0] rsp_addr_o,

  input  logic                      refill_valid_i,
  input  logic [TAG_ADDR_WIDHT-1:0] refill_addr_i,
  input  logic [TAG_WIDHT-1:0]      refill_tag_i,
  output logic                      refill_ready_o,
  output logic [ICACHE_N_WAY-1:0]   refill_way_o,

  input  logic                      inval_req_i,
  output logic                      inval_busy_o,

  output logic [ICACHE_N_WAY-1:0]   tag_req_o,
  output logic                      tag_we_o,
  output logic                      tag_vbit_o,
  output logic [TAG_WIDHT-1:0]      tag_data_o,
  output logic [TAG_ADDR_WIDHT-1:0] tag_addr_o
);

  // Round-robin pointer needs at least one bit even for a direct-mapped cache.
  localparam int RR_W = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;

  localparam logic [TAG_ADDR_WIDHT-1:0] LAST_SET = TAG_ADDR_WIDHT'(TAG_DEPTH - 1);
  localparam logic [RR_W-1:0]           LAST_WAY = RR_W'(ICACHE_N_WAY - 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t                    state;
  logic [TAG_ADDR_WIDHT-1:0] sweep_cnt;
  logic [RR_W-1:0]           rr_ptr;

  logic                      sweeping;
  logic                      take_inval;
  logic                      grant_refill;
  logic                      grant_lookup;
  logic [ICACHE_N_WAY-1:0]   victim_way;

  logic                      rsp_vld_p1;
  logic [TAG_ADDR_WIDHT-1:0] rsp_addr_p1;

  // One-hot decode of a way index.
  function automatic logic [ICACHE_N_WAY-1:0] way_onehot(input logic [RR_W-1:0] idx);
    logic [ICACHE_N_WAY-1:0] oh;
    oh = '0;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      oh[w] = (idx == RR_W'(w));
    end
    return oh;
  endfunction

  // Next victim pointer; explicit wrap keeps non-power-of-two way counts correct.
  function automatic logic [RR_W-1:0] rr_advance(input logic [RR_W-1:0] idx);
    if (idx == LAST_WAY) begin
      return '0;
    end
    return idx + RR_W'(1);
  endfunction

  // Port arbitration: invalidate beats refill beats lookup, nothing while sweeping.
  always_comb begin
    sweeping     = (state != IDLE);
    take_inval   = !sweeping && inval_req_i;
    grant_refill = !sweeping && !inval_req_i && refill_valid_i;
    grant_lookup = !sweeping && !inval_req_i && !refill_valid_i && lookup_valid_i;
    victim_way   = way_onehot(rr_ptr);
  end

  // Handshake and status outputs.
  always_comb begin
    lookup_ready_o = grant_lookup;
    refill_ready_o = grant_refill;
    inval_busy_o   = sweeping;
    refill_way_o   = sweeping ? '0 : victim_way;
  end

  // Tag-array port drive for the current owner of the port.
  always_comb begin
    tag_req_o  = '0;
    tag_we_o   = 1'b0;
    tag_vbit_o = 1'b0;
    tag_data_o = '0;
    tag_addr_o = '0;
    if (sweeping) begin
      tag_req_o  = '1;
      tag_we_o   = 1'b1;
      tag_addr_o = sweep_cnt;
    end else if (take_inval) begin
      tag_req_o  = '0;
    end else if (grant_refill) begin
      tag_req_o  = victim_way;
      tag_we_o   = 1'b1;
      tag_vbit_o = 1'b1;
      tag_data_o = refill_tag_i;
      tag_addr_o = refill_addr_i;
    end else if (grant_lookup) begin
      tag_req_o  = '1;
      tag_addr_o = lookup_addr_i;
    end
  end

  // Controller FSM: sweep counter, state and round-robin victim pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= INIT;
      sweep_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        INIT, SWEEP: begin
          // Requests arriving mid-sweep are absorbed; the sweep never restarts.
          if (sweep_cnt == LAST_SET) begin
            sweep_cnt <= '0;
            state     <= IDLE;
          end else begin
            sweep_cnt <= sweep_cnt + TAG_ADDR_WIDHT'(1);
          end
        end
        IDLE: begin
          if (inval_req_i) begin
            state <= SWEEP;
          end else if (refill_valid_i) begin
            rr_ptr <= rr_advance(rr_ptr);
          end
        end
        default: begin
          state     <= INIT;
          sweep_cnt <= '0;
        end
      endcase
    end
  end

  // ---- stage p1: lookup response valid, aligned with the array read data ----
  // Response valid is control and is cleared by reset, dropping any pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_vld_p1 <= 1'b0;
    end else begin
      rsp_vld_p1 <= grant_lookup;
    end
  end

  // Response set index is data only; it is qualified by rsp_vld_p1.
  always_ff @(posedge clk_i) begin
    if (grant_lookup) begin
      rsp_addr_p1 <= lookup_addr_i;
    end
  end

  assign rsp_valid_o = rsp_vld_p1;
  assign rsp_addr_o  = rsp_addr_p1;

endmodule

// File: tb/tb_sargantana_itag_ctrl.sv
// Self-checking bench for sargantana_itag_ctrl: a cycle-level behavioural model
// compared against the DUT every cycle, directed scenarios with literal
// expectations, and a constrained-random phase.
module tb_sargantana_itag_ctrl;

  localparam int NW = 4;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam int TW = 20;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          lookup_valid_i;
  logic [AW-1:0] lookup_addr_i;
  logic          lookup_ready_o;
  logic          rsp_valid_o;
  logic [AW-1:0] rsp_addr_o;
  logic          refill_valid_i;
  logic [AW-1:0] refill_addr_i;
  logic [TW-1:0] refill_tag_i;
  logic          refill_ready_o;
  logic [NW-1:0] refill_way_o;
  logic          inval_req_i;
  logic          inval_busy_o;
  logic [NW-1:0] tag_req_o;
  logic          tag_we_o;
  logic          tag_vbit_o;
  logic [TW-1:0] tag_data_o;
  logic [AW-1:0] tag_addr_o;

  sargantana_itag_ctrl #(
    .ICACHE_N_WAY(NW), .TAG_DEPTH(DEPTH), .TAG_ADDR_WIDHT(AW), .TAG_WIDHT(TW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i),
    .lookup_ready_o(lookup_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_addr_o(rsp_addr_o),
    .refill_valid_i(refill_valid_i), .refill_addr_i(refill_addr_i),
    .refill_tag_i(refill_tag_i), .refill_ready_o(refill_ready_o), .refill_way_o(refill_way_o),
    .inval_req_i(inval_req_i), .inval_busy_o(inval_busy_o),
    .tag_req_o(tag_req_o), .tag_we_o(tag_we_o), .tag_vbit_o(tag_vbit_o),
    .tag_data_o(tag_data_o), .tag_addr_o(tag_addr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // busy: a sweep is running and is writing set 'pos'; rr: next victim way index.
  bit m_ok = 0;
  bit m_busy, n_busy;
  int m_pos, n_pos;
  int m_rr, n_rr;
  bit m_rsp, n_rsp;
  int m_rsp_a, n_rsp_a;

  always @(negedge clk_i) begin
    if (m_ok) begin
      n_busy = m_busy; n_pos = m_pos; n_rr = m_rr; n_rsp = 0; n_rsp_a = m_rsp_a;
      chk("rsp_valid", rsp_valid_o, m_rsp);
      if (m_rsp) chk("rsp_addr", rsp_addr_o, m_rsp_a);
      chk("inval_busy", inval_busy_o, m_busy);
      if (m_busy) begin
        chk("sweep_req", tag_req_o, (1 << NW) - 1);
        chk("sweep_we", tag_we_o, 1);
        chk("sweep_vbit", tag_vbit_o, 0);
        chk("sweep_data", tag_data_o, 0);
        chk("sweep_addr", tag_addr_o, m_pos);
        chk("sweep_lready", lookup_ready_o, 0);
        chk("sweep_rready", refill_ready_o, 0);
        chk("sweep_way", refill_way_o, 0);
        if (m_pos == DEPTH - 1) begin n_busy = 0; n_pos = 0; end
        else n_pos = m_pos + 1;
      end else begin
        chk("idle_way", refill_way_o, 1 << m_rr);
        if (inval_req_i) begin
          chk("inval_req", tag_req_o, 0);
          chk("inval_we", tag_we_o, 0);
          chk("inval_lready", lookup_ready_o, 0);
          chk("inval_rready", refill_ready_o, 0);
          n_busy = 1; n_pos = 0;
        end else if (refill_valid_i) begin
          chk("refill_ready", refill_ready_o, 1);
          chk("refill_lready", lookup_ready_o, 0);
          chk("refill_req", tag_req_o, 1 << m_rr);
          chk("refill_we", tag_we_o, 1);
          chk("refill_vbit", tag_vbit_o, 1);
          chk("refill_data", tag_data_o, refill_tag_i);
          chk("refill_addr", tag_addr_o, refill_addr_i);
          n_rr = (m_rr + 1) % NW;
        end else if (lookup_valid_i) begin
          chk("lookup_ready", lookup_ready_o, 1);
          chk("lookup_rready", refill_ready_o, 0);
          chk("lookup_req", tag_req_o, (1 << NW) - 1);
          chk("lookup_we", tag_we_o, 0);
          chk("lookup_addr", tag_addr_o, lookup_addr_i);
          n_rsp = 1; n_rsp_a = lookup_addr_i;
        end else begin
          chk("quiet_req", tag_req_o, 0);
          chk("quiet_we", tag_we_o, 0);
          chk("quiet_lready", lookup_ready_o, 0);
          chk("quiet_rready", refill_ready_o, 0);
        end
      end
    end
  end

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_ok <= 1; m_busy <= 1; m_pos <= 0; m_rr <= 0; m_rsp <= 0;
    end else if (m_ok) begin
      m_busy <= n_busy; m_pos <= n_pos; m_rr <= n_rr; m_rsp <= n_rsp; m_rsp_a <= n_rsp_a;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Call just after a clock edge in the first busy cycle; returns at the
  // falling edge of the first idle cycle with the number of busy cycles seen.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    @(negedge clk_i);
    while (inval_busy_o && cycles < 200) begin
      tick();
      @(negedge clk_i);
      cycles++;
    end
    if (cycles >= 200) chk("sweep_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int cnt;
  int k;
  logic [AW-1:0] laddrs [3];
  logic [NW-1:0] ways [5];
  logic lr_s, rf_s;

  initial begin
    laddrs = '{6'd5, 6'd9, 6'd12};
    ways   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_i = 1; lookup_valid_i = 0; lookup_addr_i = '0; refill_valid_i = 0;
    refill_addr_i = '0; refill_tag_i = '0; inval_req_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 0;
    lookup_valid_i = 1; lookup_addr_i = 0;

    // Init sweep after reset, with a lookup already waiting.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk_i);
      chk("init_addr", tag_addr_o, i);
      chk("init_we", tag_we_o, 1);
      chk("init_req", tag_req_o, 4'b1111);
      chk("init_vbit", tag_vbit_o, 0);
      chk("init_busy", inval_busy_o, 1);
      chk("init_lready", lookup_ready_o, 0);
      tick();
    end
    @(negedge clk_i);
    chk("init_done_busy", inval_busy_o, 0);
    chk("init_done_lready", lookup_ready_o, 1);

    // Back-to-back lookups.
    for (int j = 0; j < 4; j++) begin
      tick();
      if (j < 3) lookup_addr_i = laddrs[j];
      else lookup_valid_i = 0;
      @(negedge clk_i);
      if (j < 3) chk("b2b_lready", lookup_ready_o, 1);
      if (j > 0) begin
        chk("b2b_rsp_valid", rsp_valid_o, 1);
        chk("b2b_rsp_addr", rsp_addr_o, laddrs[j-1]);
      end
    end
    tick();
    @(negedge clk_i);
    chk("b2b_rsp_end", rsp_valid_o, 0);

    // Five refills: round-robin victim.
    tick();
    refill_valid_i = 1; refill_addr_i = 3; refill_tag_i = 20'hABCDE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("rr_ready", refill_ready_o, 1);
      chk("rr_way", refill_way_o, ways[i]);
      chk("rr_req", tag_req_o, ways[i]);
      chk("rr_vbit", tag_vbit_o, 1);
      chk("rr_data", tag_data_o, 20'hABCDE);
      chk("rr_addr", tag_addr_o, 3);
      tick();
    end
    refill_valid_i = 0;

    // All three requests together: invalidate wins, then refill, then lookup.
    lookup_valid_i = 1; lookup_addr_i = 11;
    refill_valid_i = 1; refill_addr_i = 2; refill_tag_i = 20'h12345;
    inval_req_i = 1;
    @(negedge clk_i);
    chk("tri_lready", lookup_ready_o, 0);
    chk("tri_rready", refill_ready_o, 0);
    chk("tri_req", tag_req_o, 0);
    tick();
    inval_req_i = 0;
    wait_idle(cnt);
    chk("tri_sweep_len", cnt, 64);
    chk("tri_refill_first", refill_ready_o, 1);
    chk("tri_refill_way", refill_way_o, 4'b0010);
    chk("tri_lookup_wait", lookup_ready_o, 0);
    tick();
    refill_valid_i = 0;
    @(negedge clk_i);
    chk("tri_lookup_next", lookup_ready_o, 1);
    tick();
    lookup_valid_i = 0;
    @(negedge clk_i);
    chk("tri_rsp_addr", rsp_addr_o, 11);
    chk("tri_rsp_valid", rsp_valid_o, 1);

    // Invalidate request absorbed mid-sweep.
    tick();
    inval_req_i = 1;
    tick();
    inval_req_i = 0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (!inval_busy_o) break;
      chk("absorb_addr", tag_addr_o, k);
      tick();
      inval_req_i = (k == 19);
    end
    chk("absorb_len", k, 64);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk_i);
      chk("absorb_no_resweep", inval_busy_o, 0);
    end

    // Reset in the middle of a sweep.
    tick();
    inval_req_i = 1;
    tick();
    inval_req_i = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      chk("rst_sweep_addr", tag_addr_o, i);
      tick();
    end
    rst_i = 1;
    @(negedge clk_i);
    chk("rst_at30", tag_addr_o, 30);
    tick();
    rst_i = 0;
    @(negedge clk_i);
    chk("rst_restart_addr", tag_addr_o, 0);
    chk("rst_restart_busy", inval_busy_o, 1);
    tick();
    wait_idle(cnt);
    chk("rst_init_rest", cnt, 63);

    // Reset while a lookup response is pending, then victim pointer restarts.
    tick();
    lookup_valid_i = 1; lookup_addr_i = 7; rst_i = 1;
    tick();
    lookup_valid_i = 0; rst_i = 0;
    @(negedge clk_i);
    chk("rst_rsp_drop", rsp_valid_o, 0);
    chk("rst_rsp_addr0", tag_addr_o, 0);
    tick();
    wait_idle(cnt);
    chk("rst2_init_rest", cnt, 63);
    tick();
    refill_valid_i = 1; refill_addr_i = 9; refill_tag_i = 20'h00055;
    @(negedge clk_i);
    chk("rst_rr_ready", refill_ready_o, 1);
    chk("rst_rr_way", refill_way_o, 4'b0001);
    tick();
    refill_valid_i = 0;

    // Constrained-random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_i);
      lr_s = lookup_ready_o;
      rf_s = refill_ready_o;
      tick();
      if (!lookup_valid_i || lr_s || $urandom_range(0, 15) == 0) begin
        lookup_valid_i = ($urandom_range(0, 2) != 0);
        lookup_addr_i  = AW'($urandom_range(0, DEPTH - 1));
      end
      if (!refill_valid_i || rf_s || $urandom_range(0, 15) == 0) begin
        refill_valid_i = ($urandom_range(0, 3) == 0);
        refill_addr_i  = AW'($urandom_range(0, DEPTH - 1));
        refill_tag_i   = TW'($urandom);
      end
      inval_req_i = ($urandom_range(0, 59) == 0);
      rst_i       = ($urandom_range(0, 499) == 0);
    end
    lookup_valid_i = 0; refill_valid_i = 0; inval_req_i = 0; rst_i = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
